// File: rtl/uart_tx_queue.sv
// Byte FIFO feeding the osdvu uart transmitter: accepts bytes on a valid/ready
// handshake and issues one transmit pulse per byte, paced by is_transmitting.
module uart_tx_queue #(
  parameter int depth_log2   = 4,
  parameter int busy_timeout = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  output logic                  transmit,
  output logic [7:0]            tx_byte,
  input  logic                  is_transmitting,
  output logic [depth_log2:0]   level,
  output logic                  empty,
  output logic                  full,
  output logic                  busy
);

  localparam int depth = 2 ** depth_log2;
  localparam int TW    = (busy_timeout > 1) ? $clog2(busy_timeout) : 1;

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] WAIT_BUSY = 2'd1;
  localparam logic [1:0] WAIT_DONE = 2'd2;

  localparam logic [depth_log2-1:0] PTR_ONE  = 1;
  localparam logic [depth_log2:0]   LVL_ONE  = 1;
  localparam logic [TW-1:0]         T_ONE    = 1;
  localparam logic [TW-1:0]         TMO_LAST = TW'(busy_timeout - 1);

  logic [depth-1:0][7:0]   mem;
  logic [depth_log2-1:0]   rd_ptr, wr_ptr;
  logic [1:0]              state;
  logic [TW-1:0]           timer;
  logic                    push, pop;

  // level never exceeds depth, so its top bit alone marks the full condition
  assign full     = level[depth_log2];
  assign empty    = (level == '0);
  assign busy     = (state != IDLE);
  assign in_ready = !rst && !full;
  assign push     = in_valid && in_ready;
  assign pop      = (state == IDLE) && !empty && !is_transmitting;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      level    <= '0;
      transmit <= 1'b0;
      tx_byte  <= 8'h00;
      state    <= IDLE;
      timer    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (push && !pop)      level <= level + LVL_ONE;
      else if (pop && !push) level <= level - LVL_ONE;
      transmit <= 1'b0;
      case (state)
        IDLE: if (pop) begin
          tx_byte  <= mem[rd_ptr];
          rd_ptr   <= rd_ptr + PTR_ONE;
          transmit <= 1'b1;
          timer    <= '0;
          state    <= WAIT_BUSY;
        end
        // a core that never acknowledges the pulse must not stall the queue
        WAIT_BUSY: begin
          if (is_transmitting)       state <= WAIT_DONE;
          else if (timer == TMO_LAST) state <= IDLE;
          else                        timer <= timer + T_ONE;
        end
        WAIT_DONE: if (!is_transmitting) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_queue.sv
// Scoreboard bench for uart_tx_queue: stimulus queues expected bytes, a monitor
// checks every transmit pulse against them; a small uart core model drives is_transmitting.
module tb_uart_tx_queue;
  logic       clk = 1'b0;
  logic       rst, in_valid, in_ready, transmit, is_transmitting;
  logic       empty, full, busy;
  logic [7:0] in_data, tx_byte;
  logic [4:0] level;

  int checks = 0, errors = 0;
  logic [7:0] exp_q[$];
  int pulse_t[$];
  int pulses = 0, cyc = 0, core_cnt = 0, frame_len = 20, np;
  bit hold = 0, resp = 1, prev_tx = 0;

  uart_tx_queue dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .transmit(transmit), .tx_byte(tx_byte), .is_transmitting(is_transmitting),
    .level(level), .empty(empty), .full(full), .busy(busy)
  );

  always #5 clk = ~clk;

  // core model: frame starts the cycle after the pulse and lasts frame_len cycles
  assign is_transmitting = hold || (core_cnt != 0);
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (resp && transmit === 1'b1) core_cnt <= frame_len;
    else if (core_cnt != 0)        core_cnt <= core_cnt - 1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (transmit === 1'b1) begin
      pulses++;
      pulse_t.push_back(cyc);
      chk("pulse_width", {31'd0, prev_tx}, 0);
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_pulse tx_byte=%0h expected no pulse at cycle %0d", tx_byte, cyc);
      end else chk("tx_byte", tx_byte, exp_q.pop_front());
    end
    prev_tx = (transmit === 1'b1);
  end

  // called just after a negedge; returns at the negedge following the accept edge
  task automatic push(input logic [7:0] b);
    int t = 0;
    in_valid = 1'b1; in_data = b; #1;
    while (!in_ready && t < 200) begin @(negedge clk); #1; t++; end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL push_timeout in_ready=0 expected 1 byte=%0h", b);
      in_valid = 1'b0;
    end else begin
      exp_q.push_back(b);
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  task automatic wait_drain(input string nm, input int maxc);
    int t = 0;
    while (!(empty && !busy && !is_transmitting && exp_q.size() == 0) && t < maxc) begin
      @(negedge clk); t++;
    end
    chk(nm, exp_q.size(), 0);
    chk({nm, "_timeout"}, (t >= maxc) ? 1 : 0, 0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_level", level, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_transmit", transmit, 0);
    chk("rst_tx_byte", tx_byte, 8'h00);
    chk("rst_busy", busy, 0);
    rst = 1'b0; #1;
    chk("in_ready_after_rst", in_ready, 1);

    // single byte: latency, level and busy release
    in_valid = 1'b1; in_data = 8'h41; exp_q.push_back(8'h41);
    @(negedge clk); in_valid = 1'b0;
    chk("t1_level_after_push", level, 1);
    chk("t1_no_pulse_yet", transmit, 0);
    np = pulses;
    @(negedge clk);
    chk("t1_pulse_2nd_cycle", transmit, 1);
    chk("t1_level_after_pop", level, 0);
    begin
      int t = 0;
      while (is_transmitting !== 1'b1 && t < 10) begin @(negedge clk); t++; end
      while (is_transmitting === 1'b1 && t < 60) begin @(negedge clk); t++; end
      chk("t1_frame_seen", (t < 60) ? 1 : 0, 1);
    end
    chk("t1_busy_at_fall", busy, 1);
    @(negedge clk);
    chk("t1_busy_released", busy, 0);
    chk("t1_one_pulse", pulses - np, 1);

    // burst fill while the core is busy
    hold = 1'b1;
    for (int i = 0; i < 16; i++) push(8'(i));
    chk("t2_level_full", level, 16);
    chk("t2_full", full, 1);
    in_valid = 1'b1; in_data = 8'h10; #1;
    chk("t2_in_ready_17th", in_ready, 0);
    @(negedge clk); in_valid = 1'b0;
    chk("t2_17th_rejected", level, 16);
    np = pulses; hold = 1'b0;
    wait_drain("t2_drain", 1500);
    chk("t2_pulse_count", pulses - np, 16);

    // push coinciding with a pop keeps level constant
    hold = 1'b1;
    for (int i = 0; i < 5; i++) push(8'hA0 + 8'(i));
    chk("t3_level5", level, 5);
    hold = 1'b0; in_valid = 1'b1; in_data = 8'hA5; exp_q.push_back(8'hA5);
    @(negedge clk); in_valid = 1'b0;
    chk("t3_level_same", level, 5);
    chk("t3_popped", transmit, 1);
    wait_drain("t3_drain", 600);

    // pointer wrap with irregular producer gaps
    frame_len = 4; np = pulses;
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      push(8'h60 + 8'(i));
    end
    wait_drain("t4_drain", 3000);
    chk("t4_pulse_count", pulses - np, 40);
    frame_len = 20;

    // unresponsive core: each pulse is abandoned after busy_timeout cycles
    resp = 1'b0; hold = 1'b1;
    for (int i = 0; i < 3; i++) push(8'hC0 + 8'(i));
    pulse_t.delete(); hold = 1'b0;
    wait_drain("t5_drain", 200);
    chk("t5_pulses", pulse_t.size(), 3);
    if (pulse_t.size() == 3) begin
      chk("t5_gap1", pulse_t[1] - pulse_t[0], 4);
      chk("t5_gap2", pulse_t[2] - pulse_t[1], 4);
    end
    resp = 1'b1;

    // reset while a frame is on the line
    hold = 1'b1;
    for (int i = 0; i < 6; i++) push(8'hD0 + 8'(i));
    hold = 1'b0;
    begin
      int t = 0;
      while (transmit !== 1'b1 && t < 20) begin @(negedge clk); t++; end
    end
    repeat (3) @(negedge clk);
    chk("t6_waiting_done", busy && is_transmitting, 1);
    chk("t6_level5", level, 5);
    rst = 1'b1; #1;
    chk("t6_in_ready_in_rst", in_ready, 0);
    @(negedge clk);
    rst = 1'b0; exp_q.delete(); #1;
    chk("t6_level", level, 0);
    chk("t6_empty", empty, 1);
    chk("t6_transmit", transmit, 0);
    chk("t6_tx_byte", tx_byte, 8'h00);
    chk("t6_busy", busy, 0);
    np = pulses;
    repeat (40) @(negedge clk);
    chk("t6_no_pulses", pulses - np, 0);
    push(8'h5A);
    wait_drain("t6_drain", 200);
    chk("t6_new_pulse", pulses - np, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/uart_tx_queue.md
Name: uart_tx_queue

Overview:
Buffered transmit front-end for the osdvu `uart` core. User logic pushes bytes through a valid/ready handshake into an internal FIFO. The block drains the FIFO one byte at a time into the core's `transmit`/`tx_byte` inputs, pacing itself on the core's `is_transmitting` output. It sits between application logic and the uart core's transmit side, letting bursts of bytes (for example message strings) be queued without overrunning the core.

Parameters:
depth_log2, 4, log2 of FIFO depth; depth = 2**depth_log2 entries (default 16).
busy_timeout, 3, number of cycles to wait for `is_transmitting` to rise after a `transmit` pulse before giving up.

Ports:
clk  input  1  master clock, shared with the uart core.
rst  input  1  synchronous reset, active-high.
in_valid  input  1  producer has a byte on `in_data`.
in_data  input  8  byte to enqueue.
in_ready  output  1  FIFO can accept; a byte is accepted on any edge where in_valid && in_ready.
transmit  output  1  one-cycle pulse to the uart core's `transmit`.
tx_byte  output  8  byte for the uart core's `tx_byte`; stable from the transmit pulse until the next pop.
is_transmitting  input  1  from the uart core; high while a frame is on the line.
level  output  depth_log2+1  current number of queued bytes (the byte in flight is not counted).
empty  output  1  level == 0.
full  output  1  level == 2**depth_log2.
busy  output  1  state != IDLE.

Behaviour:
- Reset (rst sampled high at an edge):
  - rd_ptr = 0, wr_ptr = 0, level = 0.
  - transmit = 0, tx_byte = 8'h00, state = IDLE.
  - in_ready = 0 while rst is high, and = !full otherwise.
  - Reset mid-operation discards all queued bytes and any pending pulse. The core's frame already on the line is not aborted by this block.
- FIFO:
  - Storage is a 2**depth_log2 x 8 array.
  - Pointers are depth_log2 bits wide and wrap modulo depth.
  - level is updated by +1 on push only, -1 on pop only, and is unchanged on simultaneous push and pop.
  - in_ready = !full. A push when full is impossible by handshake.
  - A push and pop in the same cycle is legal at any level between 1 and depth-1. At level == depth only the pop occurs, because in_ready is low.
  - in_data is written at mem[wr_ptr] on accept.
- State machine:
  - IDLE: if !empty && !is_transmitting, then: tx_byte <= mem[rd_ptr]; rd_ptr++; level--; transmit <= 1; go to WAIT_BUSY with timer cleared. Otherwise transmit <= 0.
  - WAIT_BUSY:
    - transmit <= 0.
    - If is_transmitting, go to WAIT_DONE.
    - Otherwise the timer increments. When the timer reaches busy_timeout, go to IDLE (guard against a core that ignored the pulse; the byte is considered sent).
  - WAIT_DONE: when is_transmitting == 0, go to IDLE.
- Timing and pulse rules:
  - transmit is exactly one cycle wide per popped byte and is never asserted outside the IDLE -> WAIT_BUSY transition.
  - Latency: a byte accepted into an empty FIFO while the core is idle produces transmit = 1 in the second cycle after the accept edge, with tx_byte equal to that byte.
  - Back-to-back bytes: the next transmit follows no earlier than 1 cycle after is_transmitting falls.
  - Byte order out equals byte order in.

Test Plan:
- Single byte, core model idle (is_transmitting rises 1 cycle after transmit, stays high 20 cycles): push 8'h41 -> transmit pulses once, 2 cycles after accept, with tx_byte = 8'h41; busy returns to 0 one cycle after is_transmitting falls; level goes 1 -> 0.
- Burst fill: push 17 bytes 8'h00..8'h10 back-to-back while is_transmitting is held high from the start -> first 16 accepted; full = 1, level = 16, in_ready = 0 on the 17th; after release, 8'h00..8'h0F appear on tx_byte in order, one pulse each.
- Simultaneous push/pop: level = 5; push in the same cycle IDLE pops -> level stays 5, and the FIFO contents order is preserved.
- Pointer wrap: stream 40 bytes with random in_valid gaps -> all 40 transmitted in order, no duplicates or losses.
- Timeout: core model never raises is_transmitting -> after each transmit pulse the block returns to IDLE after busy_timeout = 3 cycles, and the next byte pulses.
- Reset mid-operation: queue 6 bytes, assert rst for 1 cycle during WAIT_DONE -> level = 0, empty = 1, transmit = 0, tx_byte = 8'h00, state IDLE; no further pulses until a new push.
